// File: rtl/icosoc_mod_ad1_sampler.sv
// icosoc_mod_ad1_sampler: timed dual-channel PmodAD1 (AD7476A) sampler with a sample FIFO on the ctrl bus
module icosoc_mod_ad1_sampler #(
  parameter int CLOCK_FREQ_HZ = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [7:0]  ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  output logic        adc_cs,
  output logic        adc_sclk,
  input  logic        adc_d0,
  input  logic        adc_d1,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;
  state_t state;
  logic [7:0] prescale, div;
  logic [23:0] period, cnt;
  logic enable, irq_en, overflow, overrun, ph;
  logic [3:0] bitcnt;
  logic [15:0] sh0, sh1;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp, level;
  logic accept, wr, rd, ctrl_wr_en, oneshot, clear, fire, trig, div_end;
  logic push_req, pop, do_push, empty, full, busy;
  logic [31:0] status, rd_val;
  always_comb begin
    accept = (ctrl_wr | ctrl_rd) & ~ctrl_done;
    wr = accept & ctrl_wr;
    rd = accept & ctrl_rd;
    ctrl_wr_en = wr && ctrl_addr == 8'h08;
    oneshot = ctrl_wr_en & ctrl_wdat[1];
    clear = ctrl_wr_en & ctrl_wdat[2];
    fire = enable && cnt == period;
    trig = fire | oneshot;
    busy = state != IDLE;
    div_end = div == prescale;
    level = wp - rp;
    empty = level == '0;
    full = level[AW];
    push_req = state == SHIFT && ph && bitcnt == 4'd15 && div_end;
    pop = rd && ctrl_addr == 8'h10 && !empty;
    // a full FIFO still accepts a push when the same cycle pops an entry
    do_push = push_req && !clear && (!full || pop);
    status = {20'b0, overrun, overflow, full, empty, 1'b0, 7'(level)};
    rd_val = ctrl_addr == 8'h00 ? {24'b0, prescale} :
             ctrl_addr == 8'h04 ? {8'b0, period} :
             ctrl_addr == 8'h08 ? {27'b0, busy, irq_en, 2'b0, enable} :
             ctrl_addr == 8'h0C ? status :
             ctrl_addr == 8'h10 ? (empty ? 32'b0 : mem[rp[AW-1:0]]) : 32'b0;
    irq = irq_en & ~empty;
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= {4'b0, sh1[11:0], 4'b0, sh0[11:0]};
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_done <= 1'b0;
      ctrl_rdat <= '0;
      prescale <= '0;
      period <= '0;
      enable <= 1'b0;
      irq_en <= 1'b0;
      overflow <= 1'b0;
      overrun <= 1'b0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      state <= IDLE;
      div <= '0;
      ph <= 1'b0;
      bitcnt <= '0;
      sh0 <= '0;
      sh1 <= '0;
      adc_cs <= 1'b1;
      adc_sclk <= 1'b1;
    end else begin
      ctrl_done <= accept;
      ctrl_rdat <= rd ? rd_val : 32'b0;
      if (wr && ctrl_addr == 8'h00) prescale <= ctrl_wdat[7:0];
      if (wr && ctrl_addr == 8'h04) period <= ctrl_wdat[23:0];
      if (ctrl_wr_en) begin
        enable <= ctrl_wdat[0];
        irq_en <= ctrl_wdat[3];
      end
      if (ctrl_wr_en && ctrl_wdat[0] && !enable) cnt <= '0;
      else if (enable) cnt <= fire ? 24'd0 : cnt + 24'd1;
      overflow <= (overflow & ~(wr && ctrl_addr == 8'h0C && ctrl_wdat[10])) |
                  (push_req && !clear && full && !pop);
      overrun <= (overrun & ~(wr && ctrl_addr == 8'h0C && ctrl_wdat[11])) | (trig && busy);
      if (clear) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (do_push) wp <= wp + (AW+1)'(1);
        if (pop) rp <= rp + (AW+1)'(1);
      end
      // every phase of the frame lasts prescale+1 cycles
      if (state == IDLE) begin
        div <= '0;
        if (trig) begin
          state <= SETUP;
          adc_cs <= 1'b0;
        end
      end else begin
        div <= div_end ? 8'd0 : div + 8'd1;
        if (div_end)
          case (state)
            SETUP: begin
              state <= SHIFT;
              adc_sclk <= 1'b0;
              ph <= 1'b0;
              bitcnt <= '0;
            end
            SHIFT:
              if (!ph) begin
                adc_sclk <= 1'b1;
                ph <= 1'b1;
                sh0 <= {sh0[14:0], adc_d0};
                sh1 <= {sh1[14:0], adc_d1};
              end else if (bitcnt == 4'd15) begin
                state <= QUIET;
                adc_cs <= 1'b1;
              end else begin
                adc_sclk <= 1'b0;
                ph <= 1'b0;
                bitcnt <= bitcnt + 4'd1;
              end
            default: state <= IDLE;
          endcase
      end
    end
  end
endmodule

// File: tb/tb_icosoc_mod_ad1_sampler.sv
// tb_icosoc_mod_ad1_sampler: scoreboard bench; reads queue expected data, a negedge monitor checks each ctrl_done
module tb_icosoc_mod_ad1_sampler;
  logic clk = 0, resetn = 0, ctrl_wr = 0, ctrl_rd = 0;
  logic [7:0] ctrl_addr = 0;
  logic [31:0] ctrl_wdat = 0, ctrl_rdat;
  logic ctrl_done, adc_cs, adc_sclk, irq;
  logic adc_d0 = 0, adc_d1 = 0;
  int n_cmp = 0, n_bad = 0;
  int fcnt = 0, bidx = 0, pat = 0;
  logic [15:0] cur0 = 0, cur1 = 0;
  logic [31:0] q_exp[$];
  bit q_chk[$];
  logic [7:0] q_tag[$];

  icosoc_mod_ad1_sampler #(.CLOCK_FREQ_HZ(0), .FIFO_DEPTH(16)) dut (
    .clk(clk), .resetn(resetn), .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd), .ctrl_addr(ctrl_addr),
    .ctrl_wdat(ctrl_wdat), .ctrl_rdat(ctrl_rdat), .ctrl_done(ctrl_done), .adc_cs(adc_cs),
    .adc_sclk(adc_sclk), .adc_d0(adc_d0), .adc_d1(adc_d1), .irq(irq));

  always #5 clk = ~clk;

  function automatic logic [15:0] word0(int k);
    return pat == 0 ? 16'h0ABC : {4'hF, 12'h100 + 12'(k)};
  endfunction
  function automatic logic [15:0] word1(int k);
    return pat == 0 ? 16'h0123 : {4'hA, 12'h800 + 12'(3 * k)};
  endfunction
  function automatic logic [31:0] expd(int k);
    logic [15:0] a, b;
    a = word0(k);
    b = word1(k);
    return {4'b0, b[11:0], 4'b0, a[11:0]};
  endfunction

  // ADC model: word latched at cs fall, one bit per sclk fall, MSB first
  always @(negedge adc_cs) begin
    cur0 = word0(fcnt);
    cur1 = word1(fcnt);
    bidx = 15;
    fcnt++;
  end
  always @(negedge adc_sclk)
    if (!adc_cs && bidx >= 0) begin
      adc_d0 = cur0[bidx];
      adc_d1 = cur1[bidx];
      bidx--;
    end

  always @(negedge clk)
    if (ctrl_done) begin : mon
      logic [31:0] e;
      bit c;
      logic [7:0] tg;
      if (q_exp.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done rdat=%08h", ctrl_rdat);
      end else begin
        e = q_exp.pop_front();
        c = q_chk.pop_front();
        tg = q_tag.pop_front();
        if (c) begin
          n_cmp++;
          if (ctrl_rdat !== e) begin
            n_bad++;
            $display("FAIL read@%02h got %08h want %08h", tg, ctrl_rdat, e);
          end
        end
      end
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    repeat (2) @(negedge clk);
    q_exp.push_back(0); q_chk.push_back(0); q_tag.push_back(a);
    ctrl_addr = a; ctrl_wdat = d; ctrl_wr = 1;
    @(posedge clk);
    #1 ctrl_wr = 0;
  endtask

  task automatic bus_rd(input logic [7:0] a, input logic [31:0] e);
    repeat (2) @(negedge clk);
    q_exp.push_back(e); q_chk.push_back(1); q_tag.push_back(a);
    ctrl_addr = a; ctrl_rd = 1;
    @(posedge clk);
    #1 ctrl_rd = 0;
  endtask

  initial begin
    int lowc, rises, runlen, k, f0;
    logic prev;
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1;
    chk("rst_cs", adc_cs, 1);
    chk("rst_sclk", adc_sclk, 1);
    chk("rst_irq", irq, 0);
    chk("rst_done", ctrl_done, 0);
    bus_rd(8'h0C, 32'h100);
    bus_rd(8'h10, 0);
    bus_rd(8'h08, 0);
    // one-shot frame at P=1
    bus_wr(8'h00, 0);
    bus_wr(8'h08, 2);
    lowc = 0; rises = 0; prev = 1;
    repeat (60) begin
      @(negedge clk);
      if (!adc_cs) lowc++;
      if (adc_sclk && !prev) rises++;
      prev = adc_sclk;
    end
    chk("cs_low_cycles", lowc, 33);
    chk("sclk_rises", rises, 16);
    bus_rd(8'h0C, 32'h001);
    bus_rd(8'h10, 32'h01230ABC);
    bus_rd(8'h0C, 32'h100);
    // fifo_clear
    bus_wr(8'h08, 2);
    repeat (50) @(posedge clk);
    bus_rd(8'h0C, 32'h001);
    bus_wr(8'h08, 4);
    bus_rd(8'h0C, 32'h100);
    // periodic: P=2, every 100 cycles, ten frames then disable
    pat = 1;
    bus_wr(8'h00, 1);
    bus_wr(8'h04, 99);
    f0 = fcnt;
    bus_wr(8'h08, 9);
    repeat (1040) @(posedge clk);
    bus_wr(8'h08, 8);
    repeat (100) @(posedge clk);
    #1 chk("irq_pending", irq, 1);
    bus_rd(8'h0C, 32'h00A);
    bus_rd(8'h08, 32'h008);
    for (int i = 0; i < 10; i++) bus_rd(8'h10, expd(f0 + i));
    chk("irq_drained", irq, 0);
    bus_rd(8'h0C, 32'h100);
    // overflow: 20 frames into 16 entries
    bus_wr(8'h00, 0);
    bus_wr(8'h04, 39);
    f0 = fcnt;
    bus_wr(8'h08, 1);
    k = 0;
    while (fcnt - f0 < 20 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    chk("ovf_frames_started", 32'(fcnt - f0 >= 20), 1);
    bus_wr(8'h08, 0);
    repeat (60) @(posedge clk);
    #1 chk("irq_masked", irq, 0);
    bus_rd(8'h0C, 32'h610);
    bus_wr(8'h0C, 32'h400);
    bus_rd(8'h0C, 32'h210);
    for (int i = 0; i < 16; i++) bus_rd(8'h10, expd(f0 + i));
    bus_rd(8'h0C, 32'h100);
    // overrun: PERIOD+1 shorter than a frame
    bus_wr(8'h04, 9);
    bus_wr(8'h08, 1);
    runlen = 0; prev = 1;
    repeat (195) begin
      @(negedge clk);
      if (!adc_cs) runlen++;
      else begin
        if (!prev) chk("cs_low_run", runlen, 33);
        runlen = 0;
      end
      prev = adc_cs;
    end
    bus_wr(8'h08, 0);
    repeat (60) @(posedge clk);
    bus_rd(8'h0C, 32'h805);
    bus_wr(8'h0C, 32'h800);
    bus_wr(8'h08, 4);
    bus_rd(8'h0C, 32'h100);
    // reset during bit 7 of a P=4 frame
    bus_wr(8'h00, 3);
    bus_wr(8'h08, 2);
    repeat (61) @(posedge clk);
    #1 resetn = 0;
    @(posedge clk);
    #1 chk("midrst_cs", adc_cs, 1);
    chk("midrst_sclk", adc_sclk, 1);
    @(negedge clk) resetn = 1;
    repeat (100) @(posedge clk);
    bus_rd(8'h0C, 32'h100);
    bus_rd(8'h00, 0);
    bus_rd(8'h10, 0);
    bus_rd(8'h14, 0);
    repeat (4) @(posedge clk);
    if (q_exp.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_done outstanding=%0d want 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
